sid_i2s_tx: RTL and testbench



---
 rtl/sid_pkg.sv | 24 ++
 rtl/sid_i2s_tx_if.sv | 26 ++
 rtl/sid_i2s_clkgen.sv | 60 ++++++
 rtl/sid_i2s_tx.sv | 118 +++++++++++
 tb/tb_sid_i2s_tx.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/sid_pkg.sv
// Shared SID audio types and I2S framing constants.
// Also holds the serializer bit-select helper used by the I2S transmitter.
package sid_pkg;

    typedef logic signed [19:0] s20_t;
    typedef logic signed [23:0] s24_t;

    localparam int unsigned I2S_SLOT_BITS = 32;
    localparam int unsigned I2S_DATA_BITS = 24;

    // Bit of the left-justified 24-bit word at slot position pos (1 = MSB); zero outside the data field.
    function automatic logic i2s_word_bit(input s20_t sample, input logic [4:0] pos);
        s24_t       word;
        logic [4:0] idx;
        word = {sample, 4'b0000};
        idx  = 5'(I2S_DATA_BITS) - pos;
        if ((pos != 5'd0) && (pos <= 5'(I2S_DATA_BITS))) begin
            return word[idx];
        end else begin
            return 1'b0;
        end
    endfunction

endpackage

// File: rtl/sid_i2s_tx_if.sv
// Sample input, status control and I2S pin bundle of the SID I2S transmitter.
// master = sample source / pin observer, slave = the transmitter.
interface sid_i2s_tx_if
    import sid_pkg::*;
();
    logic audio_valid;
    s20_t audio_l;
    s20_t audio_r;
    logic status_clr;
    logic i2s_bclk;
    logic i2s_lrclk;
    logic i2s_sdata;
    logic frame_start;
    logic underrun;
    logic overrun;

    modport master (
        output audio_valid, audio_l, audio_r, status_clr,
        input  i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun, overrun
    );

    modport slave (
        input  audio_valid, audio_l, audio_r, status_clr,
        output i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun, overrun
    );
endinterface

// File: rtl/sid_i2s_clkgen.sv
// BCLK divider and 64-bit frame position counter for the I2S transmitter.
// fe_o marks the cycle whose closing edge drops BCLK; bit_cnt_nxt_o is the position after it.
module sid_i2s_clkgen
    import sid_pkg::*;
#(
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic       bclk_o,
    output logic       fe_o,
    output logic       frame_load_o,
    output logic [5:0] bit_cnt_nxt_o
);
    localparam int unsigned DW       = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [5:0]  LAST_BIT = 6'(2 * I2S_SLOT_BITS - 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          bclk_q, bclk_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    logic          wrap_s;
    logic          fe_s;

    // Divider, BCLK and bit position registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
            bit_cnt_q <= LAST_BIT;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Next-state: BCLK toggles on divider wrap, bit position advances on each falling edge.
    always_comb begin
        wrap_s = (div_cnt_q == DW'(BCLK_DIV - 1));
        fe_s   = wrap_s && bclk_q;
        if (wrap_s) begin
            div_cnt_d = '0;
            bclk_d    = ~bclk_q;
        end else begin
            div_cnt_d = div_cnt_q + DW'(1);
            bclk_d    = bclk_q;
        end
        if (fe_s) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
        end else begin
            bit_cnt_d = bit_cnt_q;
        end
    end

    assign bclk_o        = bclk_q;
    assign fe_o          = fe_s;
    assign frame_load_o  = fe_s && (bit_cnt_q == LAST_BIT);
    assign bit_cnt_nxt_o = bit_cnt_d;

endmodule

// File: rtl/sid_i2s_tx.sv
// Philips I2S master transmitter for the two-SID stereo mix.
// Double-buffered: samples land in hold regs, frame regs feed the serializer for a whole frame.
module sid_i2s_tx
    import sid_pkg::*;
#(
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic         clk,
    input  logic         rst,
    sid_i2s_tx_if.slave  bus
);
    logic       bclk_s;
    logic       fe_s;
    logic       frame_load_s;
    logic [5:0] bit_cnt_nxt_s;

    s20_t hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    s20_t frame_l_q, frame_l_d, frame_r_q, frame_r_d;
    logic fresh_q, fresh_d;
    logic lrclk_q, lrclk_d;
    logic sdata_q, sdata_d;
    logic frame_start_q, frame_start_d;
    logic underrun_q, underrun_d;
    logic overrun_q, overrun_d;
    logic set_underrun_s;
    logic set_overrun_s;

    sid_i2s_clkgen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_clkgen (
        .clk           (clk),
        .rst           (rst),
        .bclk_o        (bclk_s),
        .fe_o          (fe_s),
        .frame_load_o  (frame_load_s),
        .bit_cnt_nxt_o (bit_cnt_nxt_s)
    );

    // Capture, frame, serializer and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_l_q      <= '0;
            hold_r_q      <= '0;
            frame_l_q     <= '0;
            frame_r_q     <= '0;
            fresh_q       <= 1'b0;
            lrclk_q       <= 1'b0;
            sdata_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            hold_l_q      <= hold_l_d;
            hold_r_q      <= hold_r_d;
            frame_l_q     <= frame_l_d;
            frame_r_q     <= frame_r_d;
            fresh_q       <= fresh_d;
            lrclk_q       <= lrclk_d;
            sdata_q       <= sdata_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            overrun_q     <= overrun_d;
        end
    end

    // Sample capture and frame load; a strobe in the load cycle bypasses straight into the frame.
    always_comb begin
        hold_l_d       = hold_l_q;
        hold_r_d       = hold_r_q;
        frame_l_d      = frame_l_q;
        frame_r_d      = frame_r_q;
        fresh_d        = fresh_q;
        set_underrun_s = 1'b0;
        set_overrun_s  = 1'b0;
        if (frame_load_s) begin
            fresh_d = 1'b0;
            if (bus.audio_valid) begin
                hold_l_d  = bus.audio_l;
                hold_r_d  = bus.audio_r;
                frame_l_d = bus.audio_l;
                frame_r_d = bus.audio_r;
            end else begin
                frame_l_d      = hold_l_q;
                frame_r_d      = hold_r_q;
                set_underrun_s = ~fresh_q;
            end
        end else if (bus.audio_valid) begin
            hold_l_d      = bus.audio_l;
            hold_r_d      = bus.audio_r;
            fresh_d       = 1'b1;
            set_overrun_s = fresh_q;
        end else begin
            fresh_d = fresh_q;
        end
        frame_start_d = frame_load_s;
        underrun_d    = set_underrun_s | (underrun_q & ~bus.status_clr);
        overrun_d     = set_overrun_s  | (overrun_q  & ~bus.status_clr);
    end

    // Word select and data bit update on each BCLK falling edge.
    always_comb begin
        if (fe_s) begin
            lrclk_d = bit_cnt_nxt_s[5];
            sdata_d = i2s_word_bit(bit_cnt_nxt_s[5] ? frame_r_q : frame_l_q, bit_cnt_nxt_s[4:0]);
        end else begin
            lrclk_d = lrclk_q;
            sdata_d = sdata_q;
        end
    end

    assign bus.i2s_bclk    = bclk_s;
    assign bus.i2s_lrclk   = lrclk_q;
    assign bus.i2s_sdata   = sdata_q;
    assign bus.frame_start = frame_start_q;
    assign bus.underrun    = underrun_q;
    assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_sid_i2s_tx.sv
// Directed bench for sid_i2s_tx at BCLK_DIV=2: captures whole 64-bit frames off the pins
// and compares them with frames built from the sample values written into the stimulus.
module tb_sid_i2s_tx;
    logic clk;
    logic rst;
    int   cyc;
    int   n_assert;
    int   n_fail;

    sid_i2s_tx_if bus ();

    sid_i2s_tx #(
        .BCLK_DIV (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_frame(input logic [19:0] l, input logic [19:0] r);
        logic [23:0] wl;
        logic [23:0] wr;
        logic [63:0] f;
        wl = {l, 4'h0};
        wr = {r, 4'h0};
        f  = 64'h0;
        for (int p = 1; p <= 24; p++) begin
            f[p]      = wl[24-p];
            f[32 + p] = wr[24-p];
        end
        return f;
    endfunction

    task automatic strobe(input logic [19:0] l, input logic [19:0] r);
        bus.audio_valid = 1'b1;
        bus.audio_l     = l;
        bus.audio_r     = r;
        @(negedge clk);
        bus.audio_valid = 1'b0;
    endtask

    task automatic clr_status();
        bus.status_clr = 1'b1;
        @(negedge clk);
        bus.status_clr = 1'b0;
    endtask

    // Waits (bounded) for frame_start, then samples sdata/lrclk after each of the 64 falling edges.
    task automatic get_frame(output logic [63:0] sd, output int fs_cyc);
        logic        found;
        logic [63:0] lr;
        found  = 1'b0;
        sd     = 64'h0;
        lr     = 64'h0;
        fs_cyc = -1;
        for (int i = 0; i < 300; i++) begin
            if (bus.frame_start === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("frame_start_seen", {63'h0, found}, 64'h1);
        if (found) begin
            fs_cyc = cyc;
            for (int k = 0; k < 64; k++) begin
                if (k != 0) repeat (4) @(negedge clk);
                sd[k] = bus.i2s_sdata;
                lr[k] = bus.i2s_lrclk;
            end
            chk("lrclk_pattern", lr, 64'hFFFF_FFFF_0000_0000);
        end
    endtask

    logic [63:0] fr;
    logic [23:0] slot;
    int          fs1;
    int          fs2;

    initial begin
        n_assert        = 0;
        n_fail          = 0;
        rst             = 1'b1;
        bus.audio_valid = 1'b0;
        bus.audio_l     = 20'h0;
        bus.audio_r     = 20'h0;
        bus.status_clr  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_bclk",        {63'h0, bus.i2s_bclk},    64'h0);
        chk("rst_lrclk",       {63'h0, bus.i2s_lrclk},   64'h0);
        chk("rst_sdata",       {63'h0, bus.i2s_sdata},   64'h0);
        chk("rst_frame_start", {63'h0, bus.frame_start}, 64'h0);
        chk("rst_underrun",    {63'h0, bus.underrun},    64'h0);
        chk("rst_overrun",     {63'h0, bus.overrun},     64'h0);
        rst = 1'b0;

        // BCLK waveform: 0,1,1,0 per 4 clk; first frame load at cycle 4 with underrun.
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("bclk_wave", {63'h0, bus.i2s_bclk}, {63'h0, ((k % 4) == 2) || ((k % 4) == 3)});
            chk("first_frame_start", {63'h0, bus.frame_start}, {63'h0, k == 4});
            if (k == 4) chk("idle_underrun", {63'h0, bus.underrun}, 64'h1);
        end

        // Idle frame: zeros, second frame_start at cycle 260.
        get_frame(fr, fs1);
        chk("idle_frame", fr, 64'h0);
        chk("frame2_cycle", 64'(fs1), 64'd260);
        clr_status();
        chk("clr_underrun", {63'h0, bus.underrun}, 64'h0);
        strobe(20'h80001, 20'h7FFFE);

        // Hand-computed slot contents for 0x80001 / 0x7FFFE.
        get_frame(fr, fs2);
        chk("frame_period", 64'(fs2 - fs1), 64'd256);
        for (int k = 1; k <= 24; k++) slot[24-k] = fr[k];
        chk("left_slot", {40'h0, slot}, 64'h800010);
        for (int k = 1; k <= 24; k++) slot[24-k] = fr[32 + k];
        chk("right_slot", {40'h0, slot}, 64'h7FFFE0);
        chk("nondata_bits", fr & ~64'h01FF_FFFE_01FF_FFFE, 64'h0);
        chk("fresh_no_underrun", {63'h0, bus.underrun}, 64'h0);
        strobe(20'h12345, 20'hABCDE);
        strobe(20'h5A5A5, 20'hC3C3C);

        // Two strobes between loads: overrun, frame carries the second.
        get_frame(fr, fs1);
        chk("overrun_set", {63'h0, bus.overrun}, 64'h1);
        chk("frame_B", fr, exp_frame(20'h5A5A5, 20'hC3C3C));
        clr_status();
        chk("clr_overrun", {63'h0, bus.overrun}, 64'h0);
        strobe(20'h11111, 20'h22222);
        @(negedge clk);
        bus.audio_valid = 1'b1;
        bus.audio_l     = 20'hFEDCB;
        bus.audio_r     = 20'h01234;
        @(negedge clk);
        bus.audio_valid = 1'b0;

        // Strobe in the load cycle bypasses into this frame with no flags.
        get_frame(fr, fs1);
        chk("bypass_frame", fr, exp_frame(20'hFEDCB, 20'h01234));
        chk("bypass_no_overrun", {63'h0, bus.overrun}, 64'h0);
        chk("bypass_no_underrun", {63'h0, bus.underrun}, 64'h0);

        // fresh cleared by the bypass: next frame repeats it and flags underrun.
        get_frame(fr, fs1);
        chk("bypass_repeat", fr, exp_frame(20'hFEDCB, 20'h01234));
        chk("bypass_fresh_clear", {63'h0, bus.underrun}, 64'h1);
        clr_status();
        strobe(20'h7FFFF, 20'h80000);

        get_frame(fr, fs1);
        chk("frame_C", fr, exp_frame(20'h7FFFF, 20'h80000));
        chk("frame_C_underrun", {63'h0, bus.underrun}, 64'h0);
        for (int n = 0; n < 3; n++) begin
            get_frame(fr, fs1);
            chk("repeat_C", fr, exp_frame(20'h7FFFF, 20'h80000));
            chk("repeat_underrun", {63'h0, bus.underrun}, 64'h1);
        end

        // Reset mid-frame at bit_cnt=40.
        for (int i = 0; i < 300; i++) begin
            if (bus.frame_start === 1'b1) break;
            @(negedge clk);
        end
        repeat (161) @(negedge clk);
        chk("midframe_lrclk", {63'h0, bus.i2s_lrclk}, 64'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_bclk",     {63'h0, bus.i2s_bclk},  64'h0);
        chk("abort_lrclk",    {63'h0, bus.i2s_lrclk}, 64'h0);
        chk("abort_sdata",    {63'h0, bus.i2s_sdata}, 64'h0);
        chk("abort_underrun", {63'h0, bus.underrun},  64'h0);
        chk("abort_overrun",  {63'h0, bus.overrun},   64'h0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.frame_start === 1'b1) break;
        end
        chk("restart_fe_cycle", 64'(cyc), 64'd4);
        chk("restart_lrclk",    {63'h0, bus.i2s_lrclk}, 64'h0);
        chk("restart_underrun", {63'h0, bus.underrun},  64'h1);
        get_frame(fr, fs1);
        chk("restart_zero_frame", fr, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
